// File: rtl/garage_input_cond_pkg.sv
// Shared defaults and helpers for the garage door input conditioning stage.
// Imported by the conditioning top level and by anything that needs the same timing defaults.
package garage_input_cond_pkg;

    localparam int SYNC_STAGES_DEF    = 2;
    localparam int DB_CYCLES_DEF      = 16;
    localparam int LOCKOUT_CYCLES_DEF = 64;

    // Raw asynchronous inputs bundled for the three conditioning channels.
    typedef struct packed {
        logic btn;
        logic up;
        logic dn;
    } cond_inputs_t;

    // Width of a counter able to hold the larger of the two cycle counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/garage_debounce.sv
// Synchroniser chain followed by a counting debouncer for one asynchronous, bouncy input.
// stable_out changes only after DB_CYCLES consecutive synchronised samples disagree with it.
module garage_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_out
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic [DB_W-1:0]        cnt_q, cnt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
        stable_d = stable_q;
        rise_d   = 1'b0;
        cnt_d    = '0;
        // Commit on the edge where the disagreement count would reach DB_CYCLES.
        if (sync_out != stable_q) begin
            if (cnt_q == DB_LAST) begin
                stable_d = sync_out;
                rise_d   = sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_out = stable_q;
    assign rise_out   = rise_q;

endmodule

// File: rtl/garage_input_cond.sv
// Conditions the button and both limit switches for the garage door controller:
// one Activate pulse per accepted press, clean limit levels and a limit-switch fault flag.
module garage_input_cond
    import garage_input_cond_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int DB_CYCLES      = DB_CYCLES_DEF,
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic Btn_raw,
    input  logic Up_sw_raw,
    input  logic Dn_sw_raw,
    output logic Activate,
    output logic Up_max,
    output logic Dn_max,
    output logic Sw_fault
);

    localparam int CNT_W = cnt_width(DB_CYCLES, LOCKOUT_CYCLES);

    cond_inputs_t raw_bundle;
    logic btn_rise;
    logic up_level, dn_level;
    logic btn_level_unused, up_rise_unused, dn_rise_unused;

    logic             activate_q, activate_d;
    logic             sw_fault_q, sw_fault_d;
    logic [CNT_W-1:0] lockout_q, lockout_d;

    assign raw_bundle = '{btn: Btn_raw, up: Up_sw_raw, dn: Dn_sw_raw};

    garage_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_btn (
        .CLK        (CLK),
        .RST        (RST),
        .raw_in     (raw_bundle.btn),
        .stable_out (btn_level_unused),
        .rise_out   (btn_rise)
    );

    garage_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_up (
        .CLK        (CLK),
        .RST        (RST),
        .raw_in     (raw_bundle.up),
        .stable_out (up_level),
        .rise_out   (up_rise_unused)
    );

    garage_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_dn (
        .CLK        (CLK),
        .RST        (RST),
        .raw_in     (raw_bundle.dn),
        .stable_out (dn_level),
        .rise_out   (dn_rise_unused)
    );

    // Presses during lockout or a registered fault are dropped, never queued.
    always_comb begin
        sw_fault_d = up_level & dn_level;
        activate_d = btn_rise & (lockout_q == '0) & ~sw_fault_q;
        lockout_d  = lockout_q;
        if (activate_d) begin
            lockout_d = CNT_W'(LOCKOUT_CYCLES);
        end else if (lockout_q != '0) begin
            lockout_d = lockout_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            activate_q <= 1'b0;
            sw_fault_q <= 1'b0;
            lockout_q  <= '0;
        end else begin
            activate_q <= activate_d;
            sw_fault_q <= sw_fault_d;
            lockout_q  <= lockout_d;
        end
    end

    assign Activate = activate_q;
    assign Up_max   = up_level;
    assign Dn_max   = dn_level;
    assign Sw_fault = sw_fault_q;

endmodule

// File: tb/tb_garage_input_cond.sv
// Directed scenarios plus randomized traffic for garage_input_cond, checked every cycle
// against a sample-history reference model of synchroniser, debounce, lockout and fault.
module tb_garage_input_cond;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int LOCK = 8;

    logic CLK, RST;
    logic Btn_raw, Up_sw_raw, Dn_sw_raw;
    logic Activate, Up_max, Dn_max, Sw_fault;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int pulses = 0;
    int last_pulse_edge = -1;
    int start_edge;

    // Reference model state
    bit sq[3][$];
    bit hist[3][$];
    bit s_lvl[3];
    bit m_rise, m_fault, m_act;
    int since;

    garage_input_cond #(
        .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .LOCKOUT_CYCLES(LOCK)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Btn_raw   (Btn_raw),
        .Up_sw_raw (Up_sw_raw),
        .Dn_sw_raw (Dn_sw_raw),
        .Activate  (Activate),
        .Up_max    (Up_max),
        .Dn_max    (Dn_max),
        .Sw_fault  (Sw_fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            sq[i].delete();
            for (int k = 0; k < SYNC; k++) sq[i].push_back(1'b0);
            hist[i].delete();
            s_lvl[i] = 1'b0;
        end
        m_rise  = 1'b0;
        m_fault = 1'b0;
        m_act   = 1'b0;
        since   = LOCK + 1;
    endfunction

    // A level is accepted once the last DB synchronised samples all oppose it.
    function automatic void model_step(input bit b, input bit u, input bit d);
        bit raw[3];
        bit old_up, old_dn, new_rise, new_act, all_opp;
        bit o;
        raw[0] = b; raw[1] = u; raw[2] = d;
        old_up = s_lvl[1];
        old_dn = s_lvl[2];
        new_rise = 1'b0;
        for (int i = 0; i < 3; i++) begin
            o = sq[i][SYNC-1];
            sq[i].push_front(raw[i]);
            void'(sq[i].pop_back());
            hist[i].push_back(o);
            if (hist[i].size() > DB) void'(hist[i].pop_front());
            all_opp = (hist[i].size() == DB);
            foreach (hist[i][k]) if (hist[i][k] == s_lvl[i]) all_opp = 1'b0;
            if (all_opp) begin
                s_lvl[i] = ~s_lvl[i];
                hist[i].delete();
                if (i == 0 && s_lvl[i]) new_rise = 1'b1;
            end
        end
        if (since <= LOCK) since++;
        new_act = m_rise && !m_fault && (since > LOCK);
        if (new_act) since = 0;
        m_fault = old_up & old_dn;
        m_rise  = new_rise;
        m_act   = new_act;
    endfunction

    task automatic compare_all(input string phase);
        chk({phase, ".activate"}, Activate, m_act);
        chk({phase, ".up_max"},   Up_max,   s_lvl[1]);
        chk({phase, ".dn_max"},   Dn_max,   s_lvl[2]);
        chk({phase, ".sw_fault"}, Sw_fault, m_fault);
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic tick();
        @(posedge CLK);
        #1;
        edge_no++;
        if (RST) model_reset();
        else model_step(Btn_raw, Up_sw_raw, Dn_sw_raw);
        if (Activate === 1'b1) begin
            pulses++;
            last_pulse_edge = edge_no;
        end
        compare_all("cyc");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hold[3];
        bit val[3];

        // Reset with all raw inputs high
        RST = 1'b1; Btn_raw = 1'b1; Up_sw_raw = 1'b1; Dn_sw_raw = 1'b1;
        model_reset();
        run(5);
        chk("rst.activate", Activate, 1'b0);
        chk("rst.up_max",   Up_max,   1'b0);
        chk("rst.dn_max",   Dn_max,   1'b0);
        chk("rst.sw_fault", Sw_fault, 1'b0);
        Btn_raw = 1'b0; Up_sw_raw = 1'b0; Dn_sw_raw = 1'b0;
        RST = 1'b0;
        pulses = 0;
        run(50);
        chk_int("idle.pulses", pulses, 0);

        // Clean press held 20 cycles
        Btn_raw = 1'b1; start_edge = edge_no; pulses = 0;
        run(20);
        chk_int("press.pulses", pulses, 1);
        chk_int("press.latency", last_pulse_edge - start_edge, SYNC + DB + 1);
        Btn_raw = 1'b0;
        run(12);

        // Bouncy press: toggle every 2 cycles then hold
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            Btn_raw = ((k / 2) % 2) == 0;
            tick();
        end
        chk_int("bounce.no_early_pulse", pulses, 0);
        Btn_raw = 1'b1; start_edge = edge_no;
        run(20);
        chk_int("bounce.pulses", pulses, 1);
        chk_int("bounce.latency", last_pulse_edge - start_edge, SYNC + DB + 1);
        Btn_raw = 1'b0;
        run(12);

        // Lockout: second press lands while lockout is still counting
        Btn_raw = 1'b1; start_edge = edge_no; pulses = 0;
        run(4);
        Btn_raw = 1'b0;
        run(4);
        Btn_raw = 1'b1;
        run(20);
        chk_int("lockout.pulses", pulses, 1);
        chk_int("lockout.latency", last_pulse_edge - start_edge, SYNC + DB + 1);
        Btn_raw = 1'b0;
        run(12);
        Btn_raw = 1'b1; pulses = 0;
        run(20);
        chk_int("after_lockout.pulses", pulses, 1);
        Btn_raw = 1'b0;
        run(12);

        // Limit switches, glitch rejection and fault
        Up_sw_raw = 1'b1;
        run(5);
        chk("up.before", Up_max, 1'b0);
        run(1);
        chk("up.edge6", Up_max, 1'b1);
        Dn_sw_raw = 1'b1;
        run(3);
        Dn_sw_raw = 1'b0;
        run(10);
        chk("dn.glitch", Dn_max, 1'b0);
        Dn_sw_raw = 1'b1;
        run(6);
        chk("dn.edge6", Dn_max, 1'b1);
        chk("fault.not_yet", Sw_fault, 1'b0);
        run(1);
        chk("fault.set", Sw_fault, 1'b1);
        Btn_raw = 1'b1; pulses = 0;
        run(15);
        chk_int("fault.press_dropped", pulses, 0);
        Btn_raw = 1'b0; Up_sw_raw = 1'b0; Dn_sw_raw = 1'b0;
        run(15);

        // Mid-operation reset with the button held
        Up_sw_raw = 1'b1;
        run(10);
        Btn_raw = 1'b1;
        run(4);
        #1 RST = 1'b1;
        #1;
        model_reset();
        chk("async.activate", Activate, 1'b0);
        chk("async.up_max",   Up_max,   1'b0);
        chk("async.dn_max",   Dn_max,   1'b0);
        chk("async.sw_fault", Sw_fault, 1'b0);
        tick();
        RST = 1'b0; start_edge = edge_no; pulses = 0;
        run(20);
        chk_int("rst_hold.pulses", pulses, 1);
        chk_int("rst_hold.latency", last_pulse_edge - start_edge, SYNC + DB + 1);
        Btn_raw = 1'b0; Up_sw_raw = 1'b0;
        run(12);

        // Randomized traffic with random hold times and occasional resets
        for (int i = 0; i < 3; i++) begin
            hold[i] = 0;
            val[i] = 1'b0;
        end
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    val[i] = ($urandom_range(0, 3) == 0) ? ~val[i] : val[i];
                    if (i > 0 && $urandom_range(0, 1) == 0) val[i] = 1'b0;
                    hold[i] = $urandom_range(1, 12);
                end else begin
                    hold[i]--;
                end
            end
            Btn_raw = val[0]; Up_sw_raw = val[1]; Dn_sw_raw = val[2];
            RST = ($urandom_range(0, 599) == 0);
            tick();
        end
        RST = 1'b0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
